// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, default sizing and the parity helper.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_state_t;

  localparam int MAX_DATA_BITS    = 9;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_CNT_W        = $clog2(DEF_CLKS_PER_BIT);

  // Data is zero-extended by the caller, so upper bits do not disturb the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; the reset value is a parameter.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, parity/framing/overrun flags, valid/ready output.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t          state, nxt;
  logic                 rxs, rxs_q, tick, done, done_r;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] sh;
  logic                 par_r, fer_r;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs));

  assign tick = (state == START) ? (cnt == HALF) : (cnt == FULL);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  always_comb begin
    nxt  = state;
    done = 1'b0;
    case (state)
      IDLE:   if (rxs_q && !rxs) nxt = START;
      START:  if (tick) nxt = rxs ? IDLE : DATA;
      DATA:   if (tick && idx == IDX_W'(DATA_BITS - 1)) nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (tick) nxt = STOP;
      STOP:   if (tick && idx == IDX_W'(STOP_BITS - 1)) begin
        done = 1'b1;
        nxt  = (fer_r || !rxs) ? BREAK : IDLE;
      end
      BREAK:  if (rxs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // The edge-detect cycle counts toward the half-bit wait, so cnt idles at 1.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rxs_q  <= 1'b1;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      par_r  <= 1'b0;
      fer_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      rxs_q  <= rxs;
      done_r <= done;
      if (state == IDLE)                    cnt <= CNT_W'(1);
      else if (tick || state == BREAK)      cnt <= '0;
      else                                  cnt <= cnt + 1'b1;
      if (state == IDLE)                    idx <= '0;
      else if (tick && (state == DATA || state == STOP))
        idx <= (nxt != state) ? '0 : idx + 1'b1;
      if (tick && state == DATA)            sh <= {rxs, sh[DATA_BITS-1:1]};
      if (state == IDLE) begin
        par_r <= 1'b0;
        fer_r <= 1'b0;
      end else begin
        if (tick && state == PARITY)
          par_r <= rxs != calc_parity(MAX_DATA_BITS'(sh), PARITY_ODD != 0);
        if (tick && state == STOP && !rxs)
          fer_r <= 1'b1;
      end
    end

  // A completion either loads a fresh word or, if one is still pending, is dropped as an overrun.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done_r && (!data_valid || data_ready)) begin
        data       <= sh;
        parity_err <= par_r;
        frame_err  <= fer_r;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (data_valid && data_ready)  overrun <= 1'b0;
      else if (done_r && data_valid) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8N1, 8E1 and 7O2 receivers driven with serial frames and checked against a frame model.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  typedef struct {
    int         ch;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  [3];
  logic       rdy [3];
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] dq  [3];
  logic       dv  [3];
  logic       pe  [3];
  logic       fe  [3];
  logic       ov  [3];
  logic       bz  [3];
  rec_t       got [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  assign dq[0] = {1'b0, d0};
  assign dq[1] = {1'b0, d1};
  assign dq[2] = {2'b0, d2};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .rx(rx[0]), .data(d0), .data_valid(dv[0]), .data_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .data(d1), .data_valid(dv[1]), .data_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_o2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .data(d2), .data_valid(dv[2]), .data_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2]));

  always #5 clk = ~clk;

  // Every accepted word (valid & ready at the coming edge) is logged mid-cycle.
  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (dv[i] && rdy[i]) got.push_back('{i, dq[i], pe[i], fe[i]});

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic send(input int ch, input logic [8:0] w, input int nb, input bit pen,
                      input logic pbit, input int ns, input logic sv);
    rx[ch] = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < nb; i++) begin
      rx[ch] = w[i];
      repeat (CPB) step();
    end
    if (pen) begin
      rx[ch] = pbit;
      repeat (CPB) step();
    end
    for (int i = 0; i < ns; i++) begin
      rx[ch] = sv;
      repeat (CPB) step();
    end
  endtask

  // Parity bit a correct transmitter would send for the low nb bits of w.
  function automatic logic ref_par(input logic [8:0] w, input int nb, input bit odd);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(w[i]);
    return ((ones % 2) != 0) ^ odd;
  endfunction

  task automatic test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ({dq[i], dv[i], pe[i], fe[i], ov[i], bz[i]} !== 14'd0) begin
          n_bad++;
          $display("FAIL reset ch%0d pass%0d: outputs d=%h v=%b pe=%b fe=%b ov=%b busy=%b, required all 0",
                   i, pass, dq[i], dv[i], pe[i], fe[i], ov[i], bz[i]);
        end
      end
      rst = 1'b0;
      repeat (5) step();
    end
  endtask

  task automatic test_latency();
    int n = 0;
    bit seen = 0;
    logic [8:0] cd;
    logic cpe, cfe, dv_next;
    got.delete();
    rdy[0] = 1'b1;
    fork
      send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
      begin
        while (!seen && n < 400) begin
          step();
          n++;
          if (dv[0]) seen = 1;
        end
        cd = dq[0]; cpe = pe[0]; cfe = fe[0];
        step();
        dv_next = dv[0];
      end
    join
    repeat (4) step();
    n_cmp++; if (!seen || n != 155) begin n_bad++; $display("FAIL latency: valid after %0d cycles (seen=%0d), required 155", n, seen); end
    n_cmp++; if ({cd, cpe, cfe} !== {9'h0A5, 2'b00}) begin n_bad++; $display("FAIL latency word: d=%h pe=%b fe=%b, required a5 0 0", cd, cpe, cfe); end
    n_cmp++; if (dv_next !== 1'b0) begin n_bad++; $display("FAIL valid pulse: valid=%b a cycle later, required 0", dv_next); end
    n_cmp++; if (got.size() != 1) begin n_bad++; $display("FAIL latency count: %0d words, required 1", got.size()); end
    rdy[0] = 1'b0;
  endtask

  task automatic test_random(input int ch, input int nb, input bit pen, input bit odd,
                             input int ns, input bit bad_par, input int cnt);
    rec_t exp_q[$];
    logic [8:0] w, mask;
    logic pb;
    mask = 9'((1 << nb) - 1);
    got.delete();
    rdy[ch] = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      w  = 9'($urandom) & mask;
      pb = ref_par(w, nb, odd) ^ (bad_par ? 1'($urandom_range(0, 1)) : 1'b0);
      exp_q.push_back('{ch, w, pen && (pb != ref_par(w, nb, odd)), 1'b0});
      send(ch, w, nb, pen, pb, ns, 1'b1);
    end
    repeat (4) step();
    rdy[ch] = 1'b0;
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rand ch%0d count: %0d words, required %0d", ch, got.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      n_cmp++;
      if (got[k].ch != ch || got[k].d !== exp_q[k].d || got[k].pe !== exp_q[k].pe || got[k].fe !== exp_q[k].fe) begin
        n_bad++;
        $display("FAIL rand ch%0d #%0d: got ch%0d d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b", ch, k,
                 got[k].ch, got[k].d, got[k].pe, got[k].fe, exp_q[k].d, exp_q[k].pe, exp_q[k].fe);
      end
    end
  endtask

  task automatic test_parity();
    got.delete();
    rdy[1] = 1'b1;
    send(1, 9'h003, 8, 1, 1'b1, 1, 1'b1);
    send(1, 9'h003, 8, 1, 1'b0, 1, 1'b1);
    repeat (4) step();
    rdy[1] = 1'b0;
    rdy[2] = 1'b1;
    send(2, 9'h041, 7, 1, 1'b1, 2, 1'b1);
    repeat (4) step();
    rdy[2] = 1'b0;
    n_cmp++;
    if (got.size() != 3) begin
      n_bad++;
      $display("FAIL parity count: %0d words, required 3", got.size());
    end else begin
      n_cmp++; if ({got[0].d, got[0].pe, got[0].fe} !== {9'h003, 2'b10}) begin n_bad++; $display("FAIL 8E1 bad parity: d=%h pe=%b fe=%b, required 003 1 0", got[0].d, got[0].pe, got[0].fe); end
      n_cmp++; if ({got[1].d, got[1].pe, got[1].fe} !== {9'h003, 2'b00}) begin n_bad++; $display("FAIL 8E1 good parity: d=%h pe=%b fe=%b, required 003 0 0", got[1].d, got[1].pe, got[1].fe); end
      n_cmp++; if ({got[2].d, got[2].pe, got[2].fe} !== {9'h041, 2'b00}) begin n_bad++; $display("FAIL 7O2 word: d=%h pe=%b fe=%b, required 041 0 0", got[2].d, got[2].pe, got[2].fe); end
    end
  endtask

  task automatic test_glitch();
    int n = 0;
    got.delete();
    rdy[0] = 1'b1;
    rx[0] = 1'b0;
    repeat (3) step();
    n_cmp++; if (bz[0] !== 1'b1) begin n_bad++; $display("FAIL glitch busy: busy=%b after start edge, required 1", bz[0]); end
    rx[0] = 1'b1;
    while (bz[0] && n < CPB / 2 + 3) begin step(); n++; end
    n_cmp++; if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL glitch idle: busy=%b after %0d cycles, required 0", bz[0], n); end
    repeat (2 * CPB) step();
    n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL glitch word: %0d words, required 0", got.size()); end
    rdy[0] = 1'b0;
  endtask

  task automatic test_break();
    logic [8:0] w;
    w = 9'($urandom_range(0, 255));
    got.delete();
    rdy[0] = 1'b1;
    send(0, w, 8, 0, 1'b0, 1, 1'b0);
    repeat (40 * CPB) step();
    n_cmp++; if (bz[0] !== 1'b1) begin n_bad++; $display("FAIL break busy: busy=%b while line low, required 1", bz[0]); end
    n_cmp++;
    if (got.size() != 1) begin
      n_bad++; $display("FAIL break count: %0d words, required 1", got.size());
    end else if ({got[0].d, got[0].pe, got[0].fe} !== {w, 2'b01}) begin
      n_bad++; $display("FAIL break word: d=%h pe=%b fe=%b, required %h 0 1", got[0].d, got[0].pe, got[0].fe, w);
    end
    rx[0] = 1'b1;
    repeat (CPB) step();
    n_cmp++; if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL break exit: busy=%b after line high, required 0", bz[0]); end
    got.delete();
    send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) step();
    n_cmp++;
    if (got.size() != 1 || {got[0].d, got[0].pe, got[0].fe} !== {9'h05A, 2'b00}) begin
      n_bad++; $display("FAIL after break: %0d words, first d=%h, required one clean 05a", got.size(), got.size() ? got[0].d : 9'h0);
    end
    rdy[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    got.delete();
    rdy[0] = 1'b0;
    send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) step();
    n_cmp++; if ({dv[0], dq[0], ov[0]} !== {1'b1, 9'h011, 1'b1}) begin n_bad++; $display("FAIL overrun hold: v=%b d=%h ov=%b, required 1 011 1", dv[0], dq[0], ov[0]); end
    rdy[0] = 1'b1; step(); rdy[0] = 1'b0; step();
    n_cmp++; if ({dv[0], ov[0]} !== 2'b00) begin n_bad++; $display("FAIL overrun accept: v=%b ov=%b, required 0 0", dv[0], ov[0]); end
    n_cmp++; if (got.size() != 1 || got[0].d !== 9'h011) begin n_bad++; $display("FAIL overrun taken: %0d words, required one 011", got.size()); end
    send(0, 9'h033, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) step();
    got.delete();
    fork
      send(0, 9'h044, 8, 0, 1'b0, 1, 1'b1);
      begin repeat (154) step(); rdy[0] = 1'b1; step(); rdy[0] = 1'b0; end
    join
    repeat (4) step();
    n_cmp++; if ({dv[0], dq[0], ov[0]} !== {1'b1, 9'h044, 1'b0}) begin n_bad++; $display("FAIL coincident: v=%b d=%h ov=%b, required 1 044 0", dv[0], dq[0], ov[0]); end
    n_cmp++; if (got.size() != 1 || got[0].d !== 9'h033) begin n_bad++; $display("FAIL coincident taken: %0d words, required one 033", got.size()); end
    rdy[0] = 1'b1; step(); rdy[0] = 1'b0; step();
  endtask

  task automatic test_reset_mid();
    logic [8:0] w;
    w = 9'($urandom_range(0, 255));
    got.delete();
    rdy[0] = 1'b0;
    send(0, 9'h077, 8, 0, 1'b0, 1, 1'b1);
    repeat (2) step();
    rx[0] = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 4; i++) begin rx[0] = w[i]; repeat (CPB) step(); end
    rx[0] = w[4];
    repeat (CPB / 2) step();
    n_cmp++; if ({dv[0], bz[0]} !== 2'b11) begin n_bad++; $display("FAIL pre-reset: v=%b busy=%b, required 1 1", dv[0], bz[0]); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({dq[0], dv[0], pe[0], fe[0], ov[0], bz[0]} !== 14'd0) begin
      n_bad++; $display("FAIL async reset: d=%h v=%b pe=%b fe=%b ov=%b busy=%b, required all 0", dq[0], dv[0], pe[0], fe[0], ov[0], bz[0]);
    end
    rx[0] = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    repeat (4) step();
    rdy[0] = 1'b1;
    send(0, 9'h0C3, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) step();
    n_cmp++;
    if (got.size() != 1 || {got[0].d, got[0].pe, got[0].fe} !== {9'h0C3, 2'b00}) begin
      n_bad++; $display("FAIL after reset: %0d words, first d=%h, required one clean 0c3", got.size(), got.size() ? got[0].d : 9'h0);
    end
    rdy[0] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin rx[i] = 1'b1; rdy[i] = 1'b0; end
    repeat (3) step();
    test_reset();
    test_latency();
    test_random(0, 8, 0, 0, 1, 0, 10);
    test_parity();
    test_random(1, 8, 1, 0, 1, 1, 10);
    test_random(2, 7, 1, 1, 2, 1, 10);
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised next-generation UART receiver. Configurable data width, parity and stop bits, with mid-bit sampling and an input synchroniser. Reports framing, parity and overrun errors, and presents each received word on a valid/ready handshake. Sits between the pad-side rx line and a byte-stream consumer such as a FIFO or CPU register block.

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; must be >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 = parity bit present after the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx  in  1  serial input, idle high, LSB first; asynchronous to clk
data  out  DATA_BITS  received word; valid while data_valid=1
data_valid  out  1  word available; held until accepted
data_ready  in  1  consumer accepts when data_valid & data_ready
parity_err  out  1  parity mismatch for the presented word
frame_err  out  1  a stop bit sampled low for the presented word
overrun  out  1  sticky; a frame was lost while a word was pending
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all outputs 0.
  - Synchroniser flops preset to 1, so no false start when reset is released.
  - A reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised rxs.
- Bit counter width is clog2(CLKS_PER_BIT); bit index width is clog2(DATA_BITS+1).
- State machine:
  - IDLE -> START when rxs goes 1->0 (falling edge detected with a registered previous value).
  - START: count CLKS_PER_BIT/2 cycles, then sample. rxs=1 means a glitch -> IDLE with no output; rxs=0 -> DATA, counter cleared.
  - DATA: sample once every CLKS_PER_BIT cycles (bit centre) and shift in LSB first. After DATA_BITS samples go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample one bit and compare against XOR of the data bits (inverted when PARITY_ODD).
  - STOP: sample STOP_BITS bits at their centres. Any low sample sets the frame error. After the final stop sample go to IDLE, or to BREAK if any stop sample was low.
  - BREAK: wait until rxs=1, then IDLE. No start is detected while in BREAK.
- Frame completion:
  - Occurs at the centre of the last stop bit, so back-to-back frames are supported.
  - The output registers update on the next cycle, so latency is 1 cycle after the last stop sample.
- Output register update:
  - If data_valid=0, or data_ready=1 in the completion cycle: load data, parity_err and frame_err; data_valid=1.
  - Otherwise: keep the pending word unchanged, set overrun=1, and drop the new frame.
- Handshake:
  - data_valid & data_ready clears data_valid next cycle, unless a frame completes in that same cycle; then the new word loads and data_valid stays 1.
  - data, parity_err and frame_err are stable while data_valid=1 and not accepted.
- overrun clears on the first accept after it was set.
  - If an accept and an overrun-causing completion coincide, the new word is taken and no overrun is flagged.
- A frame with errors is still delivered, with its error flags set.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - localparam for the counter width.
  - parity helper function, shared with the future TX block.
- Sub-module uart_sync2 is the 2-flop synchroniser with a parametrised reset value. Reused by other async inputs.

Test Plan:
- 8N1, CLKS_PER_BIT=16, data_ready=1, send 0xA5 -> data=0xA5, parity_err=0, frame_err=0; data_valid high exactly 1 cycle, rising 155 cycles after the rx falling edge (2 sync + 8 + 144 + 1).
- 8E1, send 0x03 with parity bit=1 -> data=0x03, parity_err=1. Resend with parity bit=0 -> parity_err=0. 7O2 config, send 0x41 -> correct word, no errors.
- Glitch: rx low for 3 cycles, then high -> no data_valid, busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
- Stop bit driven 0, then rx held low 40 bit times -> one word with frame_err=1, no further words; after rx=1, send 0x5A -> received clean.
- data_ready=0, send 0x11 then 0x22 back-to-back -> data stays 0x11, overrun=1. Pulse data_ready -> data_valid=0, overrun=0. Accept coincident with completion -> new word loaded, overrun stays 0.
- Assert rst at mid data bit 4 -> outputs 0 immediately (async). Release and send 0xC3 -> data=0xC3, no errors, no spurious frame.
